// File: rtl/fwd_hazard_ctrl_if.sv
// ID-to-EX hazard/forwarding bus between the decode stage and fwd_hazard_ctrl.
// Optional perf counters appear when FWD_HAZARD_PERF_EN is defined.
interface fwd_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned FWD_SEL_W  = 2
);
    logic                  hold;
    logic                  flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic [FWD_SEL_W-1:0]  ex_fwd_a_sel;
    logic [FWD_SEL_W-1:0]  ex_fwd_b_sel;
    logic                  stall;
    logic                  bubble;
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0]           perf_stall_cnt;
    logic [31:0]           perf_fwd_cnt;
`endif

    modport master (
        output hold, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread,
        input  ex_fwd_a_sel, ex_fwd_b_sel, stall, bubble
`ifdef FWD_HAZARD_PERF_EN
        , input perf_stall_cnt, perf_fwd_cnt
`endif
    );

    modport slave (
        input  hold, flush, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread,
        output ex_fwd_a_sel, ex_fwd_b_sel, stall, bubble
`ifdef FWD_HAZARD_PERF_EN
        , output perf_stall_cnt, perf_fwd_cnt
`endif
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller between ID and EX of the RV32I pipe.
// Define FWD_HAZARD_PERF_EN to add saturating stall/forward event counters.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned FWD_SEL_W  = 2
) (
    input logic              clk_i,
    input logic              rst_i,
    fwd_hazard_ctrl_if.slave bus
);
    localparam logic [FWD_SEL_W-1:0] SelRf    = '0;
    localparam logic [FWD_SEL_W-1:0] SelMemWb = FWD_SEL_W'(1);
    localparam logic [FWD_SEL_W-1:0] SelExMem = FWD_SEL_W'(2);

    logic [REG_ADDR_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
    logic                  ex_regwrite_q, mem_regwrite_q, wb_regwrite_q;
    logic                  ex_memread_q;
    logic [FWD_SEL_W-1:0]  sel_a_q, sel_b_q;
    logic [FWD_SEL_W-1:0]  sel_a_d, sel_b_d;
    logic                  ex_live, mem_live, haz, stall, bubble;

    // WB shadow is tracked for completeness; the write-through regfile covers WB->ID.
    logic unused_wb;
    assign unused_wb = ^{wb_rd_q, wb_regwrite_q};

    function automatic logic [FWD_SEL_W-1:0] pick_sel(
        input logic                  use_rs,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  ex_ok,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic                  mem_ok,
        input logic [REG_ADDR_W-1:0] mem_rd
    );
        if (use_rs && ex_ok && (ex_rd == rs)) begin
            return SelExMem;
        end else if (use_rs && mem_ok && (mem_rd == rs)) begin
            return SelMemWb;
        end
        return SelRf;
    endfunction

    always_comb begin
        ex_live  = ex_regwrite_q && (ex_rd_q != '0);
        mem_live = mem_regwrite_q && (mem_rd_q != '0);
        haz      = bus.id_valid && ex_memread_q && ex_live &&
                   ((bus.id_use_rs1 && (bus.id_rs1 == ex_rd_q)) ||
                    (bus.id_use_rs2 && (bus.id_rs2 == ex_rd_q)));
        stall    = haz && !bus.flush && !bus.hold;
        bubble   = stall || (bus.flush && !bus.hold);
        sel_a_d  = pick_sel(bus.id_use_rs1, bus.id_rs1, ex_live, ex_rd_q, mem_live, mem_rd_q);
        sel_b_d  = pick_sel(bus.id_use_rs2, bus.id_rs2, ex_live, ex_rd_q, mem_live, mem_rd_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_rd_q        <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_regwrite_q  <= 1'b0;
            sel_a_q        <= SelRf;
            sel_b_q        <= SelRf;
        end else if (!bus.hold) begin
            mem_rd_q       <= ex_rd_q;
            mem_regwrite_q <= ex_regwrite_q;
            wb_rd_q        <= mem_rd_q;
            wb_regwrite_q  <= mem_regwrite_q;
            if (bubble) begin
                ex_rd_q       <= '0;
                ex_regwrite_q <= 1'b0;
                ex_memread_q  <= 1'b0;
                sel_a_q       <= SelRf;
                sel_b_q       <= SelRf;
            end else begin
                ex_rd_q       <= bus.id_valid ? bus.id_rd : '0;
                ex_regwrite_q <= bus.id_valid && bus.id_regwrite;
                ex_memread_q  <= bus.id_valid && bus.id_memread;
                sel_a_q       <= sel_a_d;
                sel_b_q       <= sel_b_d;
            end
        end
    end

    assign bus.ex_fwd_a_sel = sel_a_q;
    assign bus.ex_fwd_b_sel = sel_b_q;
    assign bus.stall        = stall;
    assign bus.bubble       = bubble;

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_fwd_q;

    // Forward events count only when a non-zero select is actually loaded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_q <= '0;
            perf_fwd_q   <= '0;
        end else begin
            if (stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (!bus.hold && !bubble && ((sel_a_d != SelRf) || (sel_b_d != SelRf)) &&
                (perf_fwd_q != 32'hFFFF_FFFF)) begin
                perf_fwd_q <= perf_fwd_q + 32'd1;
            end
        end
    end

    assign bus.perf_stall_cnt = perf_stall_q;
    assign bus.perf_fwd_cnt   = perf_fwd_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed instruction streams with hand-derived
// per-cycle expectations, checked by an independent negedge monitor.
module tb_fwd_hazard_ctrl;
    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic       st;
        logic       bu;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];

    fwd_hazard_ctrl_if bus ();

    fwd_hazard_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic instr_t nop();
        instr_t i;
        i = '{valid: 1'b0, rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0, rd: 5'd0, rw: 1'b0,
              mr: 1'b0};
        return i;
    endfunction

    function automatic instr_t alu(input int rd, input int rs1, input int rs2);
        instr_t i;
        i = '{valid: 1'b1, rs1: 5'(rs1), rs2: 5'(rs2), u1: 1'b1, u2: 1'b1, rd: 5'(rd),
              rw: 1'b1, mr: 1'b0};
        return i;
    endfunction

    function automatic instr_t ld(input int rd, input int rs1);
        instr_t i;
        i = '{valid: 1'b1, rs1: 5'(rs1), rs2: 5'd0, u1: 1'b1, u2: 1'b0, rd: 5'(rd),
              rw: 1'b1, mr: 1'b1};
        return i;
    endfunction

    task automatic step(input logic r, input logic h, input logic f, input instr_t ins,
                        input logic chk, input logic [1:0] ea, input logic [1:0] eb,
                        input logic es, input logic ebu, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        bus.hold        = h;
        bus.flush       = f;
        bus.id_valid    = ins.valid;
        bus.id_rs1      = ins.rs1;
        bus.id_rs2      = ins.rs2;
        bus.id_use_rs1  = ins.u1;
        bus.id_use_rs2  = ins.u2;
        bus.id_rd       = ins.rd;
        bus.id_regwrite = ins.rw;
        bus.id_memread  = ins.mr;
        if (chk) begin
            e = '{a: ea, b: eb, st: es, bu: ebu, name: nm};
            exp_q.push_back(e);
        end
    endtask

    // Plain cycle: no reset/hold/flush.
    task automatic go(input instr_t ins, input logic [1:0] ea, input logic [1:0] eb,
                      input logic es, input logic ebu, input string nm);
        step(1'b0, 1'b0, 1'b0, ins, 1'b1, ea, eb, es, ebu, nm);
    endtask

    task automatic check(input string nm, input string fld, input logic [1:0] act,
                         input logic [1:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s.%s: got %0b, expected %0b", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, "sel_a", bus.ex_fwd_a_sel, e.a);
            check(e.name, "sel_b", bus.ex_fwd_b_sel, e.b);
            check(e.name, "stall", {1'b0, bus.stall}, {1'b0, e.st});
            check(e.name, "bubble", {1'b0, bus.bubble}, {1'b0, e.bu});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t inv;
        step(1'b1, 1'b0, 1'b0, nop(), 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "rst0");
        step(1'b1, 1'b0, 1'b0, nop(), 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "reset");

        // EX/MEM forward, back-to-back
        go(alu(5, 1, 2), 2'b00, 2'b00, 1'b0, 1'b0, "exfw_t1");
        go(alu(6, 5, 3), 2'b00, 2'b00, 1'b0, 1'b0, "exfw_t2");
        go(nop(),        2'b10, 2'b00, 1'b0, 1'b0, "exfw_use");
        go(nop(),        2'b00, 2'b00, 1'b0, 1'b0, "exfw_t4");
        go(nop(),        2'b00, 2'b00, 1'b0, 1'b0, "exfw_t5");

        // MEM/WB forward across a nop
        go(alu(5, 1, 2), 2'b00, 2'b00, 1'b0, 1'b0, "mwfw_t1");
        go(nop(),        2'b00, 2'b00, 1'b0, 1'b0, "mwfw_t2");
        go(alu(7, 4, 5), 2'b00, 2'b00, 1'b0, 1'b0, "mwfw_t3");
        go(nop(),        2'b00, 2'b01, 1'b0, 1'b0, "mwfw_use");
        go(nop(),        2'b00, 2'b00, 1'b0, 1'b0, "mwfw_t5");

        // Both stages match: younger wins
        go(alu(5, 1, 2), 2'b00, 2'b00, 1'b0, 1'b0, "yng_t1");
        go(alu(5, 1, 2), 2'b00, 2'b00, 1'b0, 1'b0, "yng_t2");
        go(alu(8, 5, 5), 2'b00, 2'b00, 1'b0, 1'b0, "yng_t3");
        go(nop(),        2'b10, 2'b10, 1'b0, 1'b0, "yng_use");
        go(nop(),        2'b00, 2'b00, 1'b0, 1'b0, "yng_t5");

        // Load-use: one stall, then MEM/WB forward
        go(ld(5, 1),     2'b00, 2'b00, 1'b0, 1'b0, "lu_t1");
        go(alu(7, 5, 5), 2'b00, 2'b00, 1'b1, 1'b1, "lu_stall");
        go(alu(7, 5, 5), 2'b00, 2'b00, 1'b0, 1'b0, "lu_retry");
        go(nop(),        2'b01, 2'b01, 1'b0, 1'b0, "lu_use");
        go(nop(),        2'b00, 2'b00, 1'b0, 1'b0, "lu_t5");

        // x0 never forwards or stalls
        go(alu(0, 1, 2), 2'b00, 2'b00, 1'b0, 1'b0, "x0_t1");
        go(alu(6, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0, "x0_t2");
        go(nop(),        2'b00, 2'b00, 1'b0, 1'b0, "x0_use");
        go(nop(),        2'b00, 2'b00, 1'b0, 1'b0, "x0_t4");
        go(ld(0, 1),     2'b00, 2'b00, 1'b0, 1'b0, "lx0_t1");
        go(alu(7, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0, "lx0_nostall");
        go(nop(),        2'b00, 2'b00, 1'b0, 1'b0, "lx0_t3");
        go(nop(),        2'b00, 2'b00, 1'b0, 1'b0, "lx0_t4");

        // Invalid ID slot never stalls; selects are still computed from use/rs
        inv     = nop();
        inv.rs1 = 5'd5;
        inv.u1  = 1'b1;
        go(ld(5, 1),     2'b00, 2'b00, 1'b0, 1'b0, "inv_t1");
        go(inv,          2'b00, 2'b00, 1'b0, 1'b0, "inv_nostall");
        go(nop(),        2'b10, 2'b00, 1'b0, 1'b0, "inv_t3");
        go(nop(),        2'b00, 2'b00, 1'b0, 1'b0, "inv_t4");

        // Load-use under a 3-cycle hold: frozen, then exactly one stall
        go(ld(5, 1), 2'b00, 2'b00, 1'b0, 1'b0, "hold_t1");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, alu(7, 5, 5), 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "hold_frz");
        end
        go(alu(7, 5, 5), 2'b00, 2'b00, 1'b1, 1'b1, "hold_stall");
        go(alu(7, 5, 5), 2'b00, 2'b00, 1'b0, 1'b0, "hold_retry");
        go(nop(),        2'b01, 2'b01, 1'b0, 1'b0, "hold_use");
        go(nop(),        2'b00, 2'b00, 1'b0, 1'b0, "hold_t8");

        // Flush beats load-use
        go(ld(5, 1), 2'b00, 2'b00, 1'b0, 1'b0, "fl_t1");
        step(1'b0, 1'b0, 1'b1, alu(7, 5, 5), 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, "fl_haz");
        go(nop(),    2'b00, 2'b00, 1'b0, 1'b0, "fl_t3");
        go(nop(),    2'b00, 2'b00, 1'b0, 1'b0, "fl_t4");

        // Reset mid-stall
        go(ld(5, 1), 2'b00, 2'b00, 1'b0, 1'b0, "rs_t1");
        step(1'b1, 1'b0, 1'b0, alu(7, 5, 5), 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, "rs_stall");
        go(alu(7, 5, 5), 2'b00, 2'b00, 1'b0, 1'b0, "rs_after");
        go(nop(),        2'b00, 2'b00, 1'b0, 1'b0, "rs_t4");
        go(nop(),        2'b00, 2'b00, 1'b0, 1'b0, "rs_t5");

        // Reset clears live forwarding selects
        go(alu(5, 1, 2), 2'b00, 2'b00, 1'b0, 1'b0, "rsel_t1");
        go(alu(8, 5, 5), 2'b00, 2'b00, 1'b0, 1'b0, "rsel_t2");
        step(1'b1, 1'b0, 1'b0, nop(), 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, "rsel_rst");
        go(nop(),        2'b00, 2'b00, 1'b0, 1'b0, "rsel_clr");

        @(posedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
